// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder and its backing RAM.
//   WORD        : width of one memory word and of all data buses
//   mr_state_t  : responder FSM states (MR_ prefix keeps them apart from
//                 the processor's own state names)
//   grant_t     : which requester port a transaction belongs to
package mem_responder_pkg;

    localparam int WORD = 16;

    typedef enum logic [1:0] {
        MR_IDLE   = 2'd0,
        MR_WAIT   = 2'd1,
        MR_ACCESS = 2'd2
    } mr_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array
// Single-port synchronous RAM, 2**AW words of WORD bits. Contents are never
// reset; images are loaded from outside.
// Ports:
//   clk    in   clock
//   we     in   write enable, writes wdata to addr at the rising edge
//   addr   in   word address (AW bits)
//   wdata  in   write data
//   rdata  out  registered read of addr (read-before-write on a store)
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [WORD-1:0] wdata,
    output logic [WORD-1:0] rdata
);

    logic [WORD-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Responder end of the processor memory interface. Serves instruction
// fetches (i_*) and loads/stores (d_*) from one shared single-port RAM,
// inserting WAIT_CYCLES wait states between accepting a request and
// acknowledging it.
// Parameters:
//   AW           address width in words (array depth 2**AW)
//   WAIT_CYCLES  wait states between accept and ack (0..15)
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_req/i_addr        fetch request (level, held until i_ack) and address
//   i_ack/i_rdata       one-cycle ack pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, 1=store, address, store data
//   d_ack/d_rdata       one-cycle ack pulse and load result
//   busy                high whenever the FSM is not idle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [15:0]     i_addr,
    output logic            i_ack,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [15:0]     d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_ack,
    output logic [WORD-1:0] d_rdata,
    output logic            busy
);

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mr_state_t       state;
    logic [3:0]      wait_cnt;
    grant_t          last_grant;
    grant_t          lat_grant;
    logic [AW-1:0]   lat_addr;
    logic            lat_we;
    logic [WORD-1:0] lat_wdata;

    logic            pick_data;
    logic [AW-1:0]   sel_addr;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [WORD-1:0] ram_rdata;

    // Arbitration. Data wins when it is the only requester, or on a tie
    // when instruction won the previous tie. last_grant only moves on
    // contested cycles, so alternating ties alternate winners even when
    // uncontested traffic happens in between.
    // In IDLE the RAM is addressed with the incoming request so that its
    // registered read is already valid in the first cycle after accept;
    // this is what makes WAIT_CYCLES=0 work with a synchronous RAM.
    always_comb begin
        pick_data = d_req && (!i_req || (last_grant == GRANT_INSTR));
        sel_addr  = pick_data ? d_addr[AW-1:0] : i_addr[AW-1:0];
        ram_addr  = (state == MR_IDLE) ? sel_addr : lat_addr;
        ram_we    = (state == MR_ACCESS) && (lat_grant == GRANT_DATA) && lat_we;
    end

    mem_array #(
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // Main FSM. Request fields are latched at accept so that requester
    // changes during WAIT have no effect. Acks and rdata are registered on
    // the edge that leaves ACCESS; a store only touches the RAM on that
    // edge, so a reset earlier in the transaction leaves memory untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MR_IDLE;
            wait_cnt   <= '0;
            last_grant <= GRANT_INSTR;
            lat_grant  <= GRANT_INSTR;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                MR_IDLE: begin
                    if (i_req || d_req) begin
                        lat_grant <= pick_data ? GRANT_DATA : GRANT_INSTR;
                        lat_addr  <= sel_addr;
                        lat_we    <= pick_data && d_we;
                        lat_wdata <= d_wdata;
                        if (i_req && d_req) begin
                            last_grant <= pick_data ? GRANT_DATA : GRANT_INSTR;
                        end
                        if (WAIT_CYCLES > 0) begin
                            wait_cnt <= WAIT_INIT;
                            state    <= MR_WAIT;
                        end else begin
                            state <= MR_ACCESS;
                        end
                    end
                end
                MR_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= MR_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                MR_ACCESS: begin
                    if (lat_grant == GRANT_DATA) begin
                        d_ack <= 1'b1;
                        if (!lat_we) begin
                            d_rdata <= ram_rdata;
                        end
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= ram_rdata;
                    end
                    state <= MR_IDLE;
                end
                default: begin
                    state <= MR_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != MR_IDLE);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the processor's memory interface: services instruction-fetch requests (text) and load/store requests (data) from the multi-cycle processor.
- Each port uses a req/ack handshake.
- Backing store is one single-ported 16-bit word array shared by both ports, with a configurable wait-state count.
- Sits between the processor and the memory image. It replaces direct array indexing in the processor, so memory latency becomes visible and testable.

Parameters:
- AW, 16, address width in words; array depth is 2**AW.
- WAIT_CYCLES, 2, wait states between accept and ack (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction fetch request, level, held until i_ack
- i_addr  in  16  fetch word address (pc)
- i_ack  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  16  fetched instruction word
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data word address
- d_wdata  in  16  store data
- d_ack  out  1  one-cycle pulse, load data valid / store committed
- d_rdata  out  16  load result
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async):
  - state = IDLE; i_ack, d_ack, busy = 0; i_rdata, d_rdata = 16'h0000.
  - Wait counter = 0; last_grant = INSTR.
  - Array contents are NOT cleared. A preload is done by the bench via hierarchical write or $readmemh on the array.
- States:
  - IDLE: accept when any req is high. Latch port select, address, we and wdata in that cycle. Go to WAIT if WAIT_CYCLES > 0, else ACCESS.
  - WAIT: counter counts from WAIT_CYCLES-1 down to 0, then go to ACCESS. Any req/addr changes during WAIT are ignored.
  - ACCESS (one cycle):
    - Load/fetch: read the array at the latched address into the granted port's rdata.
    - Store: write wdata to the array; d_rdata is unchanged.
    - Assert that port's ack for exactly this one registered cycle. Return to IDLE.
- Latency: req sampled high in IDLE at edge T gives ack high in the cycle after edge T+WAIT_CYCLES+1. With WAIT_CYCLES=0, ack comes one cycle after accept.
- Back-to-back: after an ack the block is in IDLE. A req still high in the ack cycle is treated as a NEW request and accepted at the next edge. Requesters must drop req in the ack cycle unless they want another transaction.
- Arbitration (both req high in IDLE): round-robin. Grant goes to the port not granted last. last_grant resets to INSTR, so data wins the first tie. A single requester is always granted.
- rdata holds its value until the next ack on the same port; the other port's traffic does not disturb it.
- Address width: only the low AW bits index the array; upper bits are ignored (wrap modulo 2**AW).
- Read-after-write: a load accepted after a store's ack returns the new value. No bypass is needed because access is serialized.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and a store not yet in ACCESS is NOT committed. A store whose ACCESS edge coincides with reset assertion is undefined; the bench must not test it.
- Never assert i_ack and d_ack in the same cycle.

Decomposition:
- Shared package/include:
  - WORD [15:0] width macro.
  - State encodings MR_IDLE, MR_WAIT, MR_ACCESS, kept disjoint from the processor's state macros.
  - Port-select constants GRANT_INSTR, GRANT_DATA.
- One natural sub-module: mem_array, a single-port synchronous 2**AW x 16 RAM with clk, we, addr, wdata, rdata. The FSM, arbiter and wait counter stay in mem_responder.

Test Plan:
1. Preload array[16'h0000]=16'hB012 (default WAIT_CYCLES=2). Pulse reset, then hold i_req=1, i_addr=0 → i_ack high exactly 3 cycles after the accept edge, i_rdata=16'hB012, d_ack stays 0, busy high for 3 cycles.
2. Store d_we=1, d_addr=16'h1234, d_wdata=16'hBEEF, then load from 16'h1234 → second d_ack carries d_rdata=16'hBEEF. i_rdata is unchanged from its prior value.
3. i_req and d_req raised in the same cycle after reset → data granted first, fetch acked 4 cycles after d_ack. Repeat the tie → fetch granted first.
4. WAIT_CYCLES=0 instance, fetch of 16'hFFFF preloaded with 16'h7001 → i_ack one cycle after accept. An i_addr of 16'h0005 with AW=2 reads array[1].
5. Assert reset during WAIT of a store (addr 16'h0010, data 16'h5555; array holds 16'h0000) → no d_ack, outputs reset, and a later load of 16'h0010 returns 16'h0000.
6. i_req held high continuously across 4 fetches to addresses 0..3 → 4 distinct i_ack pulses, each separated by WAIT_CYCLES+2 cycles, with rdata matching the preloaded words.
